// File: rtl/cordic_rotation_engine.sv
// ----------------------------------------------------------------------------
// cordic_rotation_engine
//
// Iterative CORDIC engine in rotation mode. It rotates the signed vector
// (x, y) by the angle z (Q2.14 radians) and performs one shift-add
// micro-rotation per clock. The CORDIC gain is not compensated here, so
// callers pre-scale the operands by 1/K (K ~= 1.6468).
//
// Ports
//   clk_in       rising-edge clock
//   rst_n_in     asynchronous active-low reset
//   start_in     operation request, accepted only while idle
//   x_in, y_in   signed operands, sampled on the accepting edge
//   z_in         signed rotation angle, Q2.14 radians
//   x_output     rotated x (registered)
//   y_output     rotated y (registered)
//   z_output     residual angle (registered)
//   sel_output   direction select: 0 = z >= 0 (d = +1), 1 = z < 0 (d = -1)
//   iter_output  index of the micro-rotation the next edge performs
//   busy_output  high while an operation is in progress
//   done_output  one-cycle result-valid pulse
// ----------------------------------------------------------------------------
module cordic_rotation_engine #(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned ITERATIONS = 14
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        start_in,
    input  logic signed [BIT_WIDTH-1:0] x_in,
    input  logic signed [BIT_WIDTH-1:0] y_in,
    input  logic signed [BIT_WIDTH-1:0] z_in,
    output logic signed [BIT_WIDTH-1:0] x_output,
    output logic signed [BIT_WIDTH-1:0] y_output,
    output logic signed [BIT_WIDTH-1:0] z_output,
    output logic                        sel_output,
    output logic [3:0]                  iter_output,
    output logic                        busy_output,
    output logic                        done_output
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    state_t                      r_state;
    logic signed [BIT_WIDTH-1:0] r_x;
    logic signed [BIT_WIDTH-1:0] r_y;
    logic signed [BIT_WIDTH-1:0] r_z;
    logic [3:0]                  r_iter;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_sel;
    logic signed [BIT_WIDTH-1:0] w_x_shift;
    logic signed [BIT_WIDTH-1:0] w_y_shift;
    logic signed [BIT_WIDTH-1:0] w_atan;
    logic signed [BIT_WIDTH-1:0] w_x_next;
    logic signed [BIT_WIDTH-1:0] w_y_next;
    logic signed [BIT_WIDTH-1:0] w_z_next;

    // atan(2^-i) in Q2.14 radians
    function automatic logic signed [BIT_WIDTH-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return BIT_WIDTH'(12868);
            4'd1:    return BIT_WIDTH'(7596);
            4'd2:    return BIT_WIDTH'(4014);
            4'd3:    return BIT_WIDTH'(2037);
            4'd4:    return BIT_WIDTH'(1023);
            4'd5:    return BIT_WIDTH'(512);
            4'd6:    return BIT_WIDTH'(256);
            4'd7:    return BIT_WIDTH'(128);
            4'd8:    return BIT_WIDTH'(64);
            4'd9:    return BIT_WIDTH'(32);
            4'd10:   return BIT_WIDTH'(16);
            4'd11:   return BIT_WIDTH'(8);
            4'd12:   return BIT_WIDTH'(4);
            4'd13:   return BIT_WIDTH'(2);
            default: return '0;
        endcase
    endfunction

    // Direction comes straight from the sign of the residual angle
    assign w_sel     = r_z[BIT_WIDTH-1];
    assign w_x_shift = r_x >>> r_iter;
    assign w_y_shift = r_y >>> r_iter;
    assign w_atan    = atan_lut(r_iter);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        w_z_next = r_z;
        if (w_sel) begin
            // d = -1
            w_x_next = r_x + w_y_shift;
            w_y_next = r_y - w_x_shift;
            w_z_next = r_z + w_atan;
        end else begin
            // d = +1
            w_x_next = r_x - w_y_shift;
            w_y_next = r_y + w_x_shift;
            w_z_next = r_z - w_atan;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_in) begin
                        r_x     <= x_in;
                        r_y     <= y_in;
                        r_z     <= z_in;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x <= w_x_next;
                    r_y <= w_y_next;
                    r_z <= w_z_next;
                    if (r_iter == LAST_ITER) begin
                        // iter holds at the last index so results stay frozen
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x_output    = r_x;
    assign y_output    = r_y;
    assign z_output    = r_z;
    assign sel_output  = w_sel;
    assign iter_output = r_iter;
    assign busy_output = r_busy;
    assign done_output = r_done;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// ----------------------------------------------------------------------------
// tb_cordic_rotation_engine
//
// Self-checking bench for cordic_rotation_engine. Two instances share the
// clock and reset: a default 14-iteration engine and a 4-iteration engine.
// Expected results come from a bit-exact integer model and are queued when an
// operation is started, then popped when done_output pulses.
// ----------------------------------------------------------------------------
module tb_cordic_rotation_engine;

    typedef struct {
        int x;
        int y;
        int z;
    } res_t;

    localparam int LUT [14] = '{12868, 7596, 4014, 2037, 1023, 512, 256,
                                128, 64, 32, 16, 8, 4, 2};
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic               start = 1'b0;
    logic signed [15:0] xi = '0, yi = '0, zi = '0;
    logic signed [15:0] xo, yo, zo;
    logic               sel, busy, done;
    logic [3:0]         iter;

    logic               start4 = 1'b0;
    logic signed [15:0] xi4 = '0, yi4 = '0, zi4 = '0;
    logic signed [15:0] xo4, yo4, zo4;
    logic               sel4, busy4, done4;
    logic [3:0]         iter4;

    int n_tests = 0;
    int n_fail  = 0;

    res_t exp_q[$];
    res_t exp4_q[$];

    always #5 clk = ~clk;

    cordic_rotation_engine #(.BIT_WIDTH(16), .ITERATIONS(14)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .x_in(xi), .y_in(yi), .z_in(zi),
        .x_output(xo), .y_output(yo), .z_output(zo),
        .sel_output(sel), .iter_output(iter),
        .busy_output(busy), .done_output(done)
    );

    cordic_rotation_engine #(.BIT_WIDTH(16), .ITERATIONS(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start4),
        .x_in(xi4), .y_in(yi4), .z_in(zi4),
        .x_output(xo4), .y_output(yo4), .z_output(zo4),
        .sel_output(sel4), .iter_output(iter4),
        .busy_output(busy4), .done_output(done4)
    );

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic res_t model(input int x, input int y, input int z, input int n);
        res_t r;
        int xs, ys, zs, xn, yn;
        xs = x; ys = y; zs = z;
        for (int i = 0; i < n; i++) begin
            if (zs >= 0) begin
                xn = wrap16(xs - (ys >>> i));
                yn = wrap16(ys + (xs >>> i));
                zs = wrap16(zs - LUT[i]);
            end else begin
                xn = wrap16(xs + (ys >>> i));
                yn = wrap16(ys - (xs >>> i));
                zs = wrap16(zs + LUT[i]);
            end
            xs = xn;
            ys = yn;
        end
        r.x = xs; r.y = ys; r.z = zs;
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic fail_now(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: observed none expected event", tag);
    endtask

    // Called at posedge+1; drives a one-cycle start and returns just after
    // the accepting edge.
    task automatic start_main(input int x, input int y, input int z);
        xi = 16'(x); yi = 16'(y); zi = 16'(z);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(model(x, y, z, 14));
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic wait_done(input int already, output int edges);
        edges = already;
        while (!done && edges < TIMEOUT) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done) fail_now("done_timeout");
    endtask

    task automatic check_main(input string tag);
        res_t e;
        if (exp_q.size() == 0) begin
            fail_now({tag, "_queue_empty"});
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_x"}, int'(xo), e.x);
            chk({tag, "_y"}, int'(yo), e.y);
            chk({tag, "_z"}, int'(zo), e.z);
        end
    endtask

    initial begin
        int     edges;
        int     busy_cnt;
        logic   saw_done, saw_busy;
        res_t   e;
        logic signed [15:0] hold_x;

        // ---------------- reset state ----------------
        #12;
        chk("rst_x", int'(xo), 0);
        chk("rst_y", int'(yo), 0);
        chk("rst_z", int'(zo), 0);
        chk("rst_iter", int'(iter), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy4", int'(busy4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- zero-angle rotation ----------------
        start_main(9949, 0, 0);
        chk("zero_busy_rise", int'(busy), 1);
        chk("zero_iter0", int'(iter), 0);
        wait_done(0, edges);
        chk("zero_latency", edges, 14);
        chk("zero_busy_at_done", int'(busy), 0);
        chk_tol("zero_x_ideal", int'(xo), 16384, 4);
        chk_tol("zero_y_ideal", int'(yo), 0, 4);
        chk_tol("zero_z_ideal", int'(zo), 0, 4);
        hold_x = xo;
        check_main("zero");
        @(posedge clk); #1;
        chk("zero_done_width", int'(done), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("zero_hold_x", int'(xo), int'(hold_x));

        // ---------------- +45 degree rotation ----------------
        start_main(9949, 0, 12868);
        chk("p45_sel_iter0", int'(sel), 0);
        wait_done(0, edges);
        chk("p45_latency", edges, 14);
        chk_tol("p45_x_ideal", int'(xo), 11585, 4);
        chk_tol("p45_y_ideal", int'(yo), 11585, 4);
        check_main("p45");
        @(posedge clk); #1;

        // ---------------- -90 degree rotation ----------------
        start_main(9949, 0, -25736);
        chk("m90_sel_iter0", int'(sel), 1);
        wait_done(0, edges);
        chk("m90_latency", edges, 14);
        chk_tol("m90_x_ideal", int'(xo), 0, 4);
        chk_tol("m90_y_ideal", int'(yo), -16384, 4);
        check_main("m90");
        @(posedge clk); #1;

        // ---------------- start pulses during RUN are ignored ----------------
        start_main(5000, 3000, -6000);
        edges = 0;
        for (int k = 0; k < 6; k++) begin
            start = k[0];
            xi = 16'sd1234; yi = 16'sd777; zi = 16'sd100;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        chk("pulse_iter_not_reset", int'(iter), 6);
        wait_done(edges, edges);
        chk("pulse_latency", edges, 14);
        check_main("pulse");
        @(posedge clk); #1;

        // ---------------- continuous start handshake ----------------
        xi = 16'sd9949; yi = '0; zi = '0;
        start = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model(9949, 0, 0, 14));
        busy_cnt = 0;
        edges = 0;
        while (!done && edges < TIMEOUT) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        if (!done) fail_now("cont_done_timeout");
        chk("cont_busy_cycles", busy_cnt, 14);
        chk("cont_latency", edges, 14);
        check_main("cont1");
        @(posedge clk); #1;
        chk("cont_done_one_cycle", int'(done), 0);
        chk("cont_idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("cont_restart_busy", int'(busy), 1);
        chk("cont_restart_iter", int'(iter), 0);
        exp_q.push_back(model(9949, 0, 0, 14));
        start = 1'b0;
        wait_done(0, edges);
        chk("cont2_latency", edges, 14);
        check_main("cont2");
        @(posedge clk); #1;

        // ---------------- asynchronous reset mid-RUN ----------------
        start_main(9949, 0, 12868);
        repeat (5) begin @(posedge clk); #1; end
        chk("abort_iter5", int'(iter), 5);
        rst_n = 1'b0;
        #1;
        chk("abort_x", int'(xo), 0);
        chk("abort_y", int'(yo), 0);
        chk("abort_z", int'(zo), 0);
        chk("abort_iter", int'(iter), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sel", int'(sel), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        chk("abort_no_done", int'(saw_done), 0);
        chk("abort_stays_idle", int'(saw_busy), 0);

        // ---------------- ITERATIONS = 4 instance ----------------
        xi4 = 16'sd9949; yi4 = '0; zi4 = '0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        exp4_q.push_back(model(9949, 0, 0, 4));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("it4_iter_step%0d", k), int'(iter4), k);
            chk($sformatf("it4_busy_step%0d", k), int'(busy4), 1);
            @(posedge clk); #1;
        end
        chk("it4_done_latency", int'(done4), 1);
        chk("it4_busy_low", int'(busy4), 0);
        // hand-derived result of four micro-rotations
        chk("it4_x_hand", int'(xo4), 16321);
        chk("it4_y_hand", int'(yo4), -775);
        chk("it4_z_hand", int'(zo4), 779);
        if (exp4_q.size() == 0) begin
            fail_now("it4_queue_empty");
        end else begin
            e = exp4_q.pop_front();
            chk("it4_x_model", int'(xo4), e.x);
            chk("it4_y_model", int'(yo4), e.y);
            chk("it4_z_model", int'(zo4), e.z);
        end
        @(posedge clk); #1;
        chk("it4_done_width", int'(done4), 0);

        xi4 = -16'sd7000; yi4 = 16'sd4000; zi4 = -16'sd9000;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        exp4_q.push_back(model(-7000, 4000, -9000, 4));
        edges = 0;
        while (!done4 && edges < TIMEOUT) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done4) fail_now("it4b_done_timeout");
        chk("it4b_latency", edges, 4);
        if (exp4_q.size() == 0) begin
            fail_now("it4b_queue_empty");
        end else begin
            e = exp4_q.pop_front();
            chk("it4b_x_model", int'(xo4), e.x);
            chk("it4b_y_model", int'(yo4), e.y);
            chk("it4b_z_model", int'(zo4), e.z);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
